// File: rtl/game_flow_pkg.sv
// Shared state encoding, stage numbering and registered output bundle for
// the game flow sequencer.
package game_flow_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_RESTART    = 4'd0,
    ST_WAIT_START = 4'd1,
    ST_S1_BEGIN   = 4'd2,
    ST_S1_PLAY    = 4'd3,
    ST_S1_END     = 4'd4,
    ST_S2_BEGIN   = 4'd5,
    ST_S2_PLAY    = 4'd6,
    ST_S2_END     = 4'd7,
    ST_S3_BEGIN   = 4'd8,
    ST_S3_PLAY    = 4'd9,
    ST_S3_END     = 4'd10,
    ST_WIN        = 4'd11,
    ST_OVER       = 4'd12
  } state_t;

  localparam logic [1:0] STAGE_NONE = 2'd0;
  localparam logic [1:0] STAGE_1    = 2'd1;
  localparam logic [1:0] STAGE_2    = 2'd2;
  localparam logic [1:0] STAGE_3    = 2'd3;

  // Every output of the sequencer lives in this one registered bundle.
  // stage_begin[0]/stage_done[0] belong to stage 1.
  typedef struct packed {
    logic       wait_start;
    logic [2:0] stage_begin;
    logic [2:0] stage_done;
    logic       win;
    logic       game_over;
    logic       play_enable;
    logic [1:0] stage_num;
    logic       display_resetn;
    logic       time_up;
  } flow_out_t;

  // Value held while resetn is low: title requested, display side held clear.
  localparam flow_out_t OUT_RESET = '{
    wait_start:     1'b1,
    stage_begin:    3'b000,
    stage_done:     3'b000,
    win:            1'b0,
    game_over:      1'b0,
    play_enable:    1'b0,
    stage_num:      2'd0,
    display_resetn: 1'b0,
    time_up:        1'b0
  };

  // Starting point for the decode: nothing requested, display side released.
  localparam flow_out_t OUT_IDLE = '{
    wait_start:     1'b0,
    stage_begin:    3'b000,
    stage_done:     3'b000,
    win:            1'b0,
    game_over:      1'b0,
    play_enable:    1'b0,
    stage_num:      2'd0,
    display_resetn: 1'b1,
    time_up:        1'b0
  };

  function automatic logic is_play(input state_t s);
    return (s == ST_S1_PLAY) || (s == ST_S2_PLAY) || (s == ST_S3_PLAY);
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Brings an asynchronous level into the clk domain and flags its rising edge
// for exactly one cycle, however long the level stays high.
module sync_rise_detect (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic rise
);

  logic meta;
  logic synced;
  logic prev;

  // Two-flop synchronizer followed by a delayed copy used for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta   <= 1'b0;
      synced <= 1'b0;
      prev   <= 1'b0;
    end else begin
      meta   <= d;
      synced <= meta;
      prev   <= synced;
    end
  end

  assign rise = synced & ~prev;

endmodule

// File: rtl/game_flow_control.sv
// Top-level game sequencer. Raises one display request at a time, waits for
// the display side to acknowledge it, runs the per-stage play timer and
// issues the restart clear for the display side's sticky done flags.
module game_flow_control
  import game_flow_pkg::*;
#(
  parameter int unsigned STAGE_CYCLES = 32'd3_000_000_000,
  parameter int unsigned TW           = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic start_display_done,
  input  logic stage_1_begin_done,
  input  logic stage_2_begin_done,
  input  logic stage_3_begin_done,
  input  logic stage_1_end_display_done,
  input  logic stage_2_end_display_done,
  input  logic stage_3_end_display_done,
  input  logic stage_clear,
  input  logic player_dead,
  output logic wait_start,
  output logic stage_1_begin,
  output logic stage_2_begin,
  output logic stage_3_begin,
  output logic stage_1_done,
  output logic stage_2_done,
  output logic stage_3_done,
  output logic win,
  output logic game_over,
  output logic play_enable,
  output logic [1:0] stage_num,
  output logic display_resetn,
  output logic time_up
);

  localparam logic [TW-1:0] STAGE_LOAD = TW'(STAGE_CYCLES - 32'd1);
  localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TIMER_ONE  = {{(TW-1){1'b0}}, 1'b1};

  state_t          state;
  state_t          next_state;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_next;
  logic            expired;
  logic            start_rise;
  flow_out_t       outs;
  flow_out_t       outs_next;

  sync_rise_detect u_start_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (start),
    .rise   (start_rise)
  );

  // The timer is only meaningful in PLAY; a zero reading there ends the stage.
  assign expired = is_play(state) && (timer == TIMER_ZERO);

  // Next-state logic: death or expiry in PLAY takes priority over a clear.
  always_comb begin
    next_state = state;
    case (state)
      ST_RESTART:    next_state = ST_WAIT_START;
      ST_WAIT_START: next_state = start_display_done ? ST_S1_BEGIN : ST_WAIT_START;
      ST_S1_BEGIN:   next_state = stage_1_begin_done ? ST_S1_PLAY : ST_S1_BEGIN;
      ST_S2_BEGIN:   next_state = stage_2_begin_done ? ST_S2_PLAY : ST_S2_BEGIN;
      ST_S3_BEGIN:   next_state = stage_3_begin_done ? ST_S3_PLAY : ST_S3_BEGIN;
      ST_S1_PLAY: begin
        if (player_dead || expired) begin
          next_state = ST_OVER;
        end else if (stage_clear) begin
          next_state = ST_S1_END;
        end else begin
          next_state = ST_S1_PLAY;
        end
      end
      ST_S2_PLAY: begin
        if (player_dead || expired) begin
          next_state = ST_OVER;
        end else if (stage_clear) begin
          next_state = ST_S2_END;
        end else begin
          next_state = ST_S2_PLAY;
        end
      end
      ST_S3_PLAY: begin
        if (player_dead || expired) begin
          next_state = ST_OVER;
        end else if (stage_clear) begin
          next_state = ST_S3_END;
        end else begin
          next_state = ST_S3_PLAY;
        end
      end
      ST_S1_END:     next_state = stage_1_end_display_done ? ST_S2_BEGIN : ST_S1_END;
      ST_S2_END:     next_state = stage_2_end_display_done ? ST_S3_BEGIN : ST_S2_END;
      ST_S3_END:     next_state = stage_3_end_display_done ? ST_WIN : ST_S3_END;
      ST_WIN:        next_state = start_rise ? ST_RESTART : ST_WIN;
      ST_OVER:       next_state = start_rise ? ST_RESTART : ST_OVER;
      default:       next_state = ST_WAIT_START;
    endcase
  end

  // Timer load on PLAY entry, count down while staying in PLAY, hold otherwise.
  always_comb begin
    timer_next = timer;
    if (!is_play(state) && is_play(next_state)) begin
      timer_next = STAGE_LOAD;
    end else if (is_play(state) && is_play(next_state)) begin
      timer_next = timer - TIMER_ONE;
    end else begin
      timer_next = timer;
    end
  end

  // Moore decode of the state being entered, so outputs change with the state.
  always_comb begin
    outs_next                = OUT_IDLE;
    outs_next.display_resetn = (next_state != ST_RESTART);
    outs_next.play_enable    = is_play(next_state);
    outs_next.time_up        = is_play(next_state) && (timer_next == TIMER_ZERO);
    case (next_state)
      ST_RESTART:    outs_next.stage_num = STAGE_NONE;
      ST_WAIT_START: outs_next.wait_start = 1'b1;
      ST_S1_BEGIN: begin
        outs_next.stage_begin[0] = 1'b1;
        outs_next.stage_num      = STAGE_1;
      end
      ST_S1_PLAY:    outs_next.stage_num = STAGE_1;
      ST_S1_END: begin
        outs_next.stage_done[0] = 1'b1;
        outs_next.stage_num     = STAGE_1;
      end
      ST_S2_BEGIN: begin
        outs_next.stage_begin[1] = 1'b1;
        outs_next.stage_num      = STAGE_2;
      end
      ST_S2_PLAY:    outs_next.stage_num = STAGE_2;
      ST_S2_END: begin
        outs_next.stage_done[1] = 1'b1;
        outs_next.stage_num     = STAGE_2;
      end
      ST_S3_BEGIN: begin
        outs_next.stage_begin[2] = 1'b1;
        outs_next.stage_num      = STAGE_3;
      end
      ST_S3_PLAY:    outs_next.stage_num = STAGE_3;
      ST_S3_END: begin
        outs_next.stage_done[2] = 1'b1;
        outs_next.stage_num     = STAGE_3;
      end
      ST_WIN: begin
        outs_next.win       = 1'b1;
        outs_next.stage_num = STAGE_3;
      end
      ST_OVER: begin
        // OVER is only reached from PLAY, so the current stage is the last one.
        outs_next.game_over = 1'b1;
        outs_next.stage_num = outs.stage_num;
      end
      default:       outs_next.wait_start = 1'b1;
    endcase
  end

  // State, timer and output registers share one edge and one async reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_WAIT_START;
      timer <= TIMER_ZERO;
      outs  <= OUT_RESET;
    end else begin
      state <= next_state;
      timer <= timer_next;
      outs  <= outs_next;
    end
  end

  assign wait_start     = outs.wait_start;
  assign stage_1_begin  = outs.stage_begin[0];
  assign stage_2_begin  = outs.stage_begin[1];
  assign stage_3_begin  = outs.stage_begin[2];
  assign stage_1_done   = outs.stage_done[0];
  assign stage_2_done   = outs.stage_done[1];
  assign stage_3_done   = outs.stage_done[2];
  assign win            = outs.win;
  assign game_over      = outs.game_over;
  assign play_enable    = outs.play_enable;
  assign stage_num      = outs.stage_num;
  assign display_resetn = outs.display_resetn;
  assign time_up        = outs.time_up;

endmodule

// File: tb/tb_game_flow_control.sv
// Directed bench for game_flow_control with a short stage time limit.
module tb_game_flow_control;

  logic       clk;
  logic       resetn;
  logic       start;
  logic       start_display_done;
  logic [3:1] begin_done;
  logic [3:1] end_done;
  logic       stage_clear;
  logic       player_dead;

  logic       wait_start;
  logic       stage_1_begin, stage_2_begin, stage_3_begin;
  logic       stage_1_done, stage_2_done, stage_3_done;
  logic       win, game_over, play_enable;
  logic [1:0] stage_num;
  logic       display_resetn;
  logic       time_up;

  int n_compared;
  int n_mismatched;

  // Request lines in a fixed order: wait, b1 b2 b3, d1 d2 d3, win, over, play.
  logic [9:0] req;
  assign req = {wait_start, stage_1_begin, stage_2_begin, stage_3_begin,
                stage_1_done, stage_2_done, stage_3_done, win, game_over, play_enable};

  localparam logic [9:0] VEC_WAIT = 10'b10_0000_0000;
  localparam logic [9:0] VEC_WIN  = 10'b00_0000_0100;
  localparam logic [9:0] VEC_OVER = 10'b00_0000_0010;
  localparam logic [9:0] VEC_PLAY = 10'b00_0000_0001;
  localparam logic [9:0] VEC_NONE = 10'b00_0000_0000;

  game_flow_control #(
    .STAGE_CYCLES (32'd8),
    .TW           (32)
  ) dut (
    .clk                      (clk),
    .resetn                   (resetn),
    .start                    (start),
    .start_display_done       (start_display_done),
    .stage_1_begin_done       (begin_done[1]),
    .stage_2_begin_done       (begin_done[2]),
    .stage_3_begin_done       (begin_done[3]),
    .stage_1_end_display_done (end_done[1]),
    .stage_2_end_display_done (end_done[2]),
    .stage_3_end_display_done (end_done[3]),
    .stage_clear              (stage_clear),
    .player_dead              (player_dead),
    .wait_start               (wait_start),
    .stage_1_begin            (stage_1_begin),
    .stage_2_begin            (stage_2_begin),
    .stage_3_begin            (stage_3_begin),
    .stage_1_done             (stage_1_done),
    .stage_2_done             (stage_2_done),
    .stage_3_done             (stage_3_done),
    .win                      (win),
    .game_over                (game_over),
    .play_enable              (play_enable),
    .stage_num                (stage_num),
    .display_resetn           (display_resetn),
    .time_up                  (time_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] begin_vec(input int n);
    return 10'd1 << (9 - n);
  endfunction

  function automatic logic [9:0] done_vec(input int n);
    return 10'd1 << (6 - n);
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // WAIT_START -> S1_BEGIN.
  task automatic start_game();
    start_display_done = 1'b1;
    step(1);
    start_display_done = 1'b0;
    check_value("s1_begin_req", {22'd0, req}, {22'd0, begin_vec(1)});
    check_value("s1_begin_stage", {30'd0, stage_num}, 32'd1);
  endtask

  // SN_BEGIN held for 3 cycles, then acknowledged -> SN_PLAY.
  task automatic pass_begin(input int n);
    step(3);
    check_value("begin_held", {22'd0, req}, {22'd0, begin_vec(n)});
    begin_done[n] = 1'b1;
    step(1);
    begin_done[n] = 1'b0;
    check_value("play_req", {22'd0, req}, {22'd0, VEC_PLAY});
    check_value("play_stage", {30'd0, stage_num}, n);
  endtask

  // Two PLAY cycles then a goal -> SN_END.
  task automatic clear_play(input int n);
    step(2);
    stage_clear = 1'b1;
    step(1);
    stage_clear = 1'b0;
    check_value("end_req", {22'd0, req}, {22'd0, done_vec(n)});
    check_value("end_stage", {30'd0, stage_num}, n);
  endtask

  // SN_END held for 3 cycles, then acknowledged -> next BEGIN or WIN.
  task automatic pass_end(input int n);
    step(3);
    check_value("end_held", {22'd0, req}, {22'd0, done_vec(n)});
    end_done[n] = 1'b1;
    step(1);
    end_done[n] = 1'b0;
    if (n < 3) begin
      check_value("next_begin_req", {22'd0, req}, {22'd0, begin_vec(n + 1)});
      check_value("next_begin_stage", {30'd0, stage_num}, n + 1);
    end else begin
      check_value("win_req", {22'd0, req}, {22'd0, VEC_WIN});
      check_value("win_stage", {30'd0, stage_num}, 32'd3);
    end
  endtask

  // Start press from WIN/OVER: 3 edges of synchronizer latency, one RESTART cycle.
  task automatic press_restart();
    start = 1'b1;
    step(2);
    check_value("restart_latency_dresetn", {31'd0, display_resetn}, 32'd1);
    step(1);
    check_value("restart_dresetn", {31'd0, display_resetn}, 32'd0);
    check_value("restart_req", {22'd0, req}, {22'd0, VEC_NONE});
    check_value("restart_stage", {30'd0, stage_num}, 32'd0);
    step(1);
    check_value("after_restart_req", {22'd0, req}, {22'd0, VEC_WAIT});
    check_value("after_restart_dresetn", {31'd0, display_resetn}, 32'd1);
    start = 1'b0;
    step(3);
  endtask

  initial begin
    int low_count;
    n_compared         = 0;
    n_mismatched       = 0;
    resetn             = 1'b0;
    start              = 1'b0;
    start_display_done = 1'b0;
    begin_done         = 3'b000;
    end_done           = 3'b000;
    stage_clear        = 1'b0;
    player_dead        = 1'b0;

    // Reset state.
    step(2);
    check_value("rst_req", {22'd0, req}, {22'd0, VEC_WAIT});
    check_value("rst_dresetn", {31'd0, display_resetn}, 32'd0);
    check_value("rst_stage", {30'd0, stage_num}, 32'd0);
    check_value("rst_time_up", {31'd0, time_up}, 32'd0);
    resetn = 1'b1;
    step(1);
    check_value("dresetn_rise", {31'd0, display_resetn}, 32'd1);

    // A start edge in WAIT_START is discarded; play inputs are ignored too.
    start       = 1'b1;
    stage_clear = 1'b1;
    player_dead = 1'b1;
    step(5);
    start       = 1'b0;
    stage_clear = 1'b0;
    player_dead = 1'b0;
    step(1);
    check_value("wait_ignores_start", {22'd0, req}, {22'd0, VEC_WAIT});

    // Full win path.
    start_game();
    pass_begin(1); clear_play(1); pass_end(1);
    pass_begin(2); clear_play(2); pass_end(2);
    pass_begin(3); clear_play(3); pass_end(3);
    step(3);
    check_value("win_held", {22'd0, req}, {22'd0, VEC_WIN});
    press_restart();

    // Stage 2 timeout: time_up in the 8th PLAY cycle, OVER next edge.
    start_game();
    pass_begin(1); clear_play(1); pass_end(1);
    pass_begin(2);
    for (int k = 1; k <= 8; k++) begin
      check_value($sformatf("time_up_cyc%0d", k), {31'd0, time_up}, (k == 8) ? 32'd1 : 32'd0);
      step(1);
    end
    check_value("timeout_req", {22'd0, req}, {22'd0, VEC_OVER});
    check_value("timeout_stage", {30'd0, stage_num}, 32'd2);
    check_value("timeout_time_up_low", {31'd0, time_up}, 32'd0);
    stage_clear = 1'b1;
    step(1);
    stage_clear = 1'b0;
    check_value("over_ignores_clear", {22'd0, req}, {22'd0, VEC_OVER});

    // Start held for 100 cycles in OVER gives exactly one RESTART cycle.
    start     = 1'b1;
    low_count = 0;
    for (int c = 0; c < 100; c++) begin
      step(1);
      if (display_resetn == 1'b0) low_count++;
    end
    check_value("held_start_restarts", low_count, 32'd1);
    check_value("held_start_final_req", {22'd0, req}, {22'd0, VEC_WAIT});
    start = 1'b0;
    step(3);

    // Death and clear together in S1_PLAY -> OVER, never S1_END.
    start_game();
    pass_begin(1);
    step(1);
    stage_clear = 1'b1;
    player_dead = 1'b1;
    step(1);
    stage_clear = 1'b0;
    player_dead = 1'b0;
    check_value("dead_beats_clear_req", {22'd0, req}, {22'd0, VEC_OVER});
    check_value("dead_beats_clear_stage", {30'd0, stage_num}, 32'd1);
    step(3);
    check_value("over_held", {22'd0, req}, {22'd0, VEC_OVER});
    press_restart();

    // Reset in S3_PLAY acts without a clock edge.
    start_game();
    pass_begin(1); clear_play(1); pass_end(1);
    pass_begin(2); clear_play(2); pass_end(2);
    pass_begin(3);
    #2;
    resetn = 1'b0;
    #1;
    check_value("async_play_enable", {31'd0, play_enable}, 32'd0);
    check_value("async_req", {22'd0, req}, {22'd0, VEC_WAIT});
    check_value("async_dresetn", {31'd0, display_resetn}, 32'd0);
    check_value("async_stage", {30'd0, stage_num}, 32'd0);
    step(2);
    check_value("rst_hold_dresetn", {31'd0, display_resetn}, 32'd0);
    resetn = 1'b1;
    step(1);
    check_value("rst_release_dresetn", {31'd0, display_resetn}, 32'd1);
    check_value("rst_release_req", {22'd0, req}, {22'd0, VEC_WAIT});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
